// File: rtl/memory_bus_responder.sv
// memory_bus_responder
// Responder end of the multicycle processor's memory bus. Decodes the
// processor's registered AddressOut/DOUT/Write onto a word RAM, an LED
// register and a synchronised switch input, and returns read data on DIN
// through a READ_LATENCY-deep register pipeline. After reset an INIT
// sequence clears the RAM one word per cycle before the bus goes live.
//
// DIN timing: the edge that samples AddressOut counts as the first edge;
// DIN carries the result after the READ_LATENCY-th edge. With the default
// of 2 the data lands at the end of T2 and is stable for the IR capture at
// the end of T3.
//
// Ports:
//   Clock       system clock, rising edge
//   Resetn      asynchronous active-low reset
//   AddressOut  word address; [15:12] selects region (0 RAM, 1 LED, 3 SW)
//   DOUT        write data
//   Write       write strobe
//   SW          asynchronous switch inputs (SW_BITS wide)
//   DIN         read data
//   LEDR        LED register
//   Ready       INIT complete, bus live
//   BusErr      sticky bad-access flag (only with BUS_ERR_EN defined)
//
// Optional feature macro: BUS_ERR_EN adds the BusErr output.
//
// State table:
//   ST_INIT | clearing RAM[r_clr_cnt]; writes dropped, reads return 0
//   ST_RUN  | bus serviced, Ready=1, left only by reset

module memory_bus_responder #(
    parameter int ADDR_BITS    = 7,
    parameter int READ_LATENCY = 2,
    parameter int SW_BITS      = 10
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic [15:0]        AddressOut,
    input  logic [15:0]        DOUT,
    input  logic               Write,
    input  logic [SW_BITS-1:0] SW,
    output logic [15:0]        DIN,
    output logic [15:0]        LEDR,
`ifdef BUS_ERR_EN
    output logic               Ready,
    output logic               BusErr
`else
    output logic               Ready
`endif
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [ADDR_BITS-1:0] r_clr_cnt;
    logic                 r_ready;

    logic [15:0]          r_mem [DEPTH];
    logic [15:0]          r_led;
    logic [SW_BITS-1:0]   r_sw_meta;
    logic [SW_BITS-1:0]   r_sw_sync;
    logic [15:0]          r_pipe [READ_LATENCY];

    logic [3:0]           w_region;
    logic [ADDR_BITS-1:0] w_index;
    logic                 w_run;
    logic                 w_wr_ram;
    logic                 w_wr_led;
    logic [15:0]          w_rd_data;
    logic                 w_unused;

    assign w_region = AddressOut[15:12];
    assign w_index  = AddressOut[ADDR_BITS-1:0];
    assign w_run    = (r_state == ST_RUN);
    assign w_wr_ram = w_run && Write && (w_region == 4'h0);
    assign w_wr_led = w_run && Write && (w_region == 4'h1);

    // Address bits between the RAM index and the region field alias the RAM.
    assign w_unused = &{1'b0, AddressOut[11:ADDR_BITS]};

    // INIT / RUN sequencer with registered Ready
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_clr_cnt <= r_clr_cnt + {{(ADDR_BITS-1){1'b0}}, 1'b1};
                    if (r_clr_cnt == {ADDR_BITS{1'b1}}) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state   <= ST_INIT;
                    r_clr_cnt <= '0;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    // RAM has no reset; INIT owns the write port until the sequence completes.
    always_ff @(posedge Clock) begin
        if (r_state == ST_INIT) begin
            r_mem[r_clr_cnt] <= 16'h0000;
        end else if (w_wr_ram) begin
            r_mem[w_index] <= DOUT;
        end
    end

    // Read mux sees pre-edge state, so same-edge write is read-first.
    always_comb begin
        w_rd_data = 16'h0000;
        if (w_run) begin
            case (w_region)
                4'h0:    w_rd_data = r_mem[w_index];
                4'h1:    w_rd_data = r_led;
                4'h3:    w_rd_data = {{(16-SW_BITS){1'b0}}, r_sw_sync};
                default: w_rd_data = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_led     <= 16'h0000;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe[i] <= 16'h0000;
            end
        end else begin
            r_sw_meta <= SW;
            r_sw_sync <= r_sw_meta;
            if (w_wr_led) begin
                r_led <= DOUT;
            end
            r_pipe[0] <= w_rd_data;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign DIN   = r_pipe[READ_LATENCY-1];
    assign LEDR  = r_led;
    assign Ready = r_ready;

`ifdef BUS_ERR_EN
    logic w_unmapped;
    logic r_bus_err;

    assign w_unmapped = (w_region != 4'h0) && (w_region != 4'h1) && (w_region != 4'h3);

    // Every edge samples an address, so any RUN edge on an unmapped region is
    // a bad read even without a strobe.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_bus_err <= 1'b0;
        end else if (w_run && (w_unmapped || (Write && (w_region == 4'h3)))) begin
            r_bus_err <= 1'b1;
        end
    end

    assign BusErr = r_bus_err;
`endif

endmodule

// File: tb/tb_memory_bus_responder.sv
module tb_memory_bus_responder;

    localparam int AB    = 7;
    localparam int DEPTH = 128;
    localparam int LAT   = 2;
    localparam int HIST  = 4096;

    logic        Clock;
    logic        Resetn;
    logic [15:0] addr;
    logic [15:0] dout;
    logic        wr;
    logic [9:0]  sw;
    logic [15:0] DIN;
    logic [15:0] LEDR;
    logic        Ready;
`ifdef BUS_ERR_EN
    logic        BusErr;
`endif

    memory_bus_responder #(
        .ADDR_BITS   (AB),
        .READ_LATENCY(LAT),
        .SW_BITS     (10)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .AddressOut(addr),
        .DOUT      (dout),
        .Write     (wr),
        .SW        (sw),
        .DIN       (DIN),
        .LEDR      (LEDR),
`ifdef BUS_ERR_EN
        .Ready     (Ready),
        .BusErr    (BusErr)
`else
        .Ready     (Ready)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: bus contents plus a per-edge history of read results.
    logic [15:0] m_mem [DEPTH];
    logic [15:0] m_led;
    logic        m_err;
    int          n;
    logic [15:0] res     [HIST];
    logic [15:0] sw_hist [HIST];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;
        m_led = 16'h0000;
        m_err = 1'b0;
        n     = 0;
    endtask

    task automatic tick();
        logic [15:0] v;
        logic [3:0]  rg;
        int          idx;
        @(posedge Clock);
        n++;
        if (n >= HIST) begin
            $display("FAIL history_overflow observed=%0d expected<%0d", n, HIST);
            $fatal(1, "history overflow");
        end
        sw_hist[n] = {6'b0, sw};
        rg = addr[15:12];
        v  = 16'h0000;
        if (n > DEPTH) begin
            if (rg == 4'h0)      v = m_mem[addr[AB-1:0]];
            else if (rg == 4'h1) v = m_led;
            else if (rg == 4'h3) v = (n > 2) ? sw_hist[n-2] : 16'h0000;
            else                 m_err = 1'b1;
            if (wr) begin
                if (rg == 4'h0)      m_mem[addr[AB-1:0]] = dout;
                else if (rg == 4'h1) m_led = dout;
                else                 m_err = 1'b1;
            end
        end
        res[n] = v;
        #1;
        idx = n - LAT + 1;
        check("din", DIN, (idx >= 1) ? res[idx] : 16'h0000);
        check("ledr", LEDR, m_led);
        check("ready", {15'b0, Ready}, (n >= DEPTH) ? 16'h1 : 16'h0);
`ifdef BUS_ERR_EN
        check("buserr", {15'b0, BusErr}, {15'b0, m_err});
`endif
        @(negedge Clock);
    endtask

    task automatic wait_ready(input string tag);
        int cnt;
        cnt = 0;
        while (Ready !== 1'b1 && cnt < 300) begin
            tick();
            cnt++;
        end
        check(tag, 16'(cnt), 16'(DEPTH));
    endtask

    initial begin
        Resetn = 1'b0;
        addr   = 16'h0000;
        dout   = 16'h0000;
        wr     = 1'b0;
        sw     = 10'h000;
        model_reset();
        #1;
        check("rst_din", DIN, 16'h0000);
        check("rst_ledr", LEDR, 16'h0000);
        check("rst_ready", {15'b0, Ready}, 16'h0);
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;

        // INIT length and cleared RAM
        wait_ready("init_len");
        addr = 16'h0005;
        tick(); tick();
        check("ram5_cleared", DIN, 16'h0000);

        // RAM write then read, read-first on the write edge
        wr = 1'b1; addr = 16'h0005; dout = 16'hBEEF;
        tick();
        wr = 1'b0;
        tick();
        check("read_first", DIN, 16'h0000);
        tick();
        check("ram_readback", DIN, 16'hBEEF);

        // LED register
        wr = 1'b1; addr = 16'h1000; dout = 16'h00A5;
        tick();
        check("led_write", LEDR, 16'h00A5);
        wr = 1'b0;
        tick(); tick();
        check("led_read", DIN, 16'h00A5);

        // Switch read through synchroniser and pipeline
        sw = 10'h2AA; addr = 16'h3000;
        repeat (4) tick();
        check("sw_read", DIN, 16'h02AA);

        // RAM aliasing through ignored address bits
        wr = 1'b1; addr = 16'h0085; dout = 16'h5555;
        tick();
        wr = 1'b0; addr = 16'h0005;
        tick(); tick();
        check("alias_read", DIN, 16'h5555);

        // Writes to SW / unmapped regions leave state untouched
        wr = 1'b1; addr = 16'h7000; dout = 16'h1111;
        tick();
`ifdef BUS_ERR_EN
        check("buserr_set", {15'b0, BusErr}, 16'h1);
`endif
        wr = 1'b1; addr = 16'h3000; dout = 16'h2222;
        tick();
        wr = 1'b0; addr = 16'h1000;
        tick(); tick();
        check("led_untouched", DIN, 16'h00A5);
        addr = 16'h0005;
        repeat (3) tick();
`ifdef BUS_ERR_EN
        check("buserr_sticky", {15'b0, BusErr}, 16'h1);
`endif

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            int sel;
            sel = $urandom_range(0, 5);
            addr[11:0] = 12'($urandom);
            case (sel)
                0:       addr[15:12] = 4'h0;
                1:       addr[15:12] = 4'h1;
                2:       addr[15:12] = 4'h3;
                default: addr[15:12] = 4'($urandom);
            endcase
            wr   = ($urandom_range(0, 2) == 0);
            dout = 16'($urandom);
            if ($urandom_range(0, 7) == 0) sw = 10'($urandom);
            tick();
        end
        wr = 1'b0;

        // Reset in the middle of INIT restarts the clear
        addr = 16'h0000;
        Resetn = 1'b0;
        model_reset();
        @(negedge Clock);
        Resetn = 1'b1;
        repeat (60) tick();
        Resetn = 1'b0;
        #1;
        check("midrst_ready", {15'b0, Ready}, 16'h0);
        check("midrst_din", DIN, 16'h0000);
        check("midrst_ledr", LEDR, 16'h0000);
`ifdef BUS_ERR_EN
        check("midrst_buserr", {15'b0, BusErr}, 16'h0);
`endif
        model_reset();
        @(negedge Clock);
        Resetn = 1'b1;
        repeat (5) tick();
        wr = 1'b1; addr = 16'h0007; dout = 16'h1234;
        tick();
        wr = 1'b0; addr = 16'h0000;
        // 6 INIT edges already taken; the remainder must total exactly 128
        begin
            int cnt;
            cnt = 6;
            while (Ready !== 1'b1 && cnt < 300) begin
                tick();
                cnt++;
            end
            check("reinit_len", 16'(cnt), 16'(DEPTH));
        end
        addr = 16'h0007;
        tick(); tick();
        check("init_write_dropped", DIN, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
